reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 8 +
 rtl/reorder_buffer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer and its neighbours in the dispatch path.
package reorder_buffer_pkg;
    localparam int ROBWidth  = 4;
    localparam int ROBCount  = 1 << ROBWidth;
    localparam int IDWidth   = 32;
    localparam int RegWidth  = 5;
    localparam int AddrWidth = 32;
endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order completion via CDB, in-order commit.
// Define ROB_FLUSH_EN to add branch misprediction recovery (flush on commit of a mispredicted branch).
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROBWidth = reorder_buffer_pkg::ROBWidth,
    parameter int IDWidth  = reorder_buffer_pkg::IDWidth,
    parameter int RegWidth = reorder_buffer_pkg::RegWidth
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 dispatcher_rob_en_in,
    input  logic [RegWidth-1:0]  dispatcher_rob_rd_in,
    output logic                 rob_dispatcher_full_out,
    output logic [ROBWidth-1:0]  rob_dispatcher_reorder_out,
    input  logic [ROBWidth-1:0]  dispatcher_rob_rs_reorder_in,
    input  logic [ROBWidth-1:0]  dispatcher_rob_rt_reorder_in,
    output logic                 rob_dispatcher_rs_ready_out,
    output logic [IDWidth-1:0]   rob_dispatcher_rs_value_out,
    output logic                 rob_dispatcher_rt_ready_out,
    output logic [IDWidth-1:0]   rob_dispatcher_rt_value_out,
    input  logic                 cdb_rob_en_in,
    input  logic [ROBWidth-1:0]  cdb_rob_reorder_in,
    input  logic [IDWidth-1:0]   cdb_rob_value_in,
`ifdef ROB_FLUSH_EN
    input  logic                 dispatcher_rob_is_branch_in,
    input  logic                 cdb_rob_mispredict_in,
    input  logic [AddrWidth-1:0] cdb_rob_pc_in,
    output logic                 rob_flush_out,
    output logic [AddrWidth-1:0] rob_pc_out,
`endif
    output logic                 rob_regfile_en_out,
    output logic [RegWidth-1:0]  rob_regfile_rd_out,
    output logic [IDWidth-1:0]   rob_regfile_value_out,
    output logic [ROBWidth-1:0]  rob_regfile_reorder_out
);

    localparam int Depth = 1 << ROBWidth;
    localparam logic [ROBWidth:0] CountFull = {1'b1, {ROBWidth{1'b0}}};

    logic [ROBWidth-1:0] head_q, head_d;
    logic [ROBWidth-1:0] tail_q, tail_d;
    logic [ROBWidth:0]   count_q, count_d;
    logic [Depth-1:0]    busy_q, busy_d;
    logic [Depth-1:0]    ready_q, ready_d;
    logic [RegWidth-1:0] rd_q    [Depth];
    logic [IDWidth-1:0]  value_q [Depth];

    logic                commit_en_q;
    logic [RegWidth-1:0] commit_rd_q;
    logic [IDWidth-1:0]  commit_value_q;
    logic [ROBWidth-1:0] commit_tag_q;

    logic full;
    logic alloc_ok;
    logic cdb_ok;
    logic commit_ok;
    logic flush_hit;
    logic rs_hit;
    logic rt_hit;

`ifdef ROB_FLUSH_EN
    logic [Depth-1:0]     branch_q;
    logic [Depth-1:0]     mispredict_q;
    logic [AddrWidth-1:0] pc_q [Depth];
    logic                 flush_q;
    logic [AddrWidth-1:0] pc_out_q;
`endif

    assign full = (count_q == CountFull);

    // Commit looks only at registered ready bits, so a CDB write never bypasses into the same edge.
    always_comb begin
        alloc_ok  = rdy_in && dispatcher_rob_en_in && !full;
        cdb_ok    = rdy_in && cdb_rob_en_in && busy_q[cdb_rob_reorder_in];
        commit_ok = rdy_in && (count_q != '0) && ready_q[head_q];
`ifdef ROB_FLUSH_EN
        flush_hit = commit_ok && branch_q[head_q] && mispredict_q[head_q];
`else
        flush_hit = 1'b0;
`endif
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        if (cdb_ok) begin
            ready_d[cdb_rob_reorder_in] = 1'b1;
        end
        if (alloc_ok) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            tail_d          = tail_q + ROBWidth'(1);
        end
        if (commit_ok) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + ROBWidth'(1);
        end
        count_d = count_q + (ROBWidth+1)'(alloc_ok) - (ROBWidth+1)'(commit_ok);
        if (flush_hit) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            busy_d  = '0;
            ready_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            commit_en_q    <= 1'b0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_tag_q   <= '0;
`ifdef ROB_FLUSH_EN
            flush_q        <= 1'b0;
            pc_out_q       <= '0;
`endif
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            commit_en_q    <= commit_ok && (rd_q[head_q] != '0);
            commit_rd_q    <= commit_ok ? rd_q[head_q]    : '0;
            commit_value_q <= commit_ok ? value_q[head_q] : '0;
            commit_tag_q   <= commit_ok ? head_q          : '0;
`ifdef ROB_FLUSH_EN
            flush_q        <= flush_hit;
            pc_out_q       <= flush_hit ? pc_q[head_q] : '0;
`endif
        end
    end

    // Payload storage is only meaningful while the matching busy bit is set, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (alloc_ok) begin
            rd_q[tail_q] <= dispatcher_rob_rd_in;
        end
        if (cdb_ok) begin
            value_q[cdb_rob_reorder_in] <= cdb_rob_value_in;
        end
`ifdef ROB_FLUSH_EN
        if (alloc_ok) begin
            branch_q[tail_q]     <= dispatcher_rob_is_branch_in;
            mispredict_q[tail_q] <= 1'b0;
        end
        if (cdb_ok) begin
            mispredict_q[cdb_rob_reorder_in] <= cdb_rob_mispredict_in;
            pc_q[cdb_rob_reorder_in]         <= cdb_rob_pc_in;
        end
`endif
    end

    always_comb begin
        rs_hit = cdb_rob_en_in && (cdb_rob_reorder_in == dispatcher_rob_rs_reorder_in);
        rt_hit = cdb_rob_en_in && (cdb_rob_reorder_in == dispatcher_rob_rt_reorder_in);
        rob_dispatcher_rs_ready_out = ready_q[dispatcher_rob_rs_reorder_in] || rs_hit;
        rob_dispatcher_rt_ready_out = ready_q[dispatcher_rob_rt_reorder_in] || rt_hit;
        rob_dispatcher_rs_value_out = rs_hit ? cdb_rob_value_in : value_q[dispatcher_rob_rs_reorder_in];
        rob_dispatcher_rt_value_out = rt_hit ? cdb_rob_value_in : value_q[dispatcher_rob_rt_reorder_in];
    end

    assign rob_dispatcher_full_out    = full;
    assign rob_dispatcher_reorder_out = tail_q;
    assign rob_regfile_en_out         = commit_en_q;
    assign rob_regfile_rd_out         = commit_rd_q;
    assign rob_regfile_value_out      = commit_value_q;
    assign rob_regfile_reorder_out    = commit_tag_q;
`ifdef ROB_FLUSH_EN
    assign rob_flush_out = flush_q;
    assign rob_pc_out    = pc_out_q;
`endif

endmodule
